// File: rtl/neuron_sweep_scheduler_pkg.sv
// Shared encodings for the neuron sweep scheduler: FSM states and RAM phase codes.
package neuron_sweep_scheduler_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Per-neuron RAM phases (low two bits of neuronCounter)
    localparam logic [1:0] PH_WCNT  = 2'd0;  // write-count strobe
    localparam logic [1:0] PH_READ  = 2'd1;  // state RAM read
    localparam logic [1:0] PH_COMP  = 2'd2;  // neuron compute settle, no strobe
    localparam logic [1:0] PH_WRITE = 2'd3;  // state RAM write-back

endpackage

// File: rtl/neuron_sweep_scheduler_half_cnt_divider.sv
// Programmable half-period divider producing neuron_clk and a one-cycle
// tick that is high in the first cycle neuron_clk is high.
module half_cnt_divider (
    input  logic        rawclk,
    input  logic        reset_sim_n,
    input  logic [31:0] half_cnt,
    output logic        neuron_clk,
    output logic        tick
);

    logic [31:0] delay_cnt;

    // Count up to half_cnt, then toggle; >= compare makes a lowered half_cnt take effect next edge
    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            delay_cnt  <= 32'd0;
            neuron_clk <= 1'b0;
            tick       <= 1'b0;
        end else if (delay_cnt >= half_cnt) begin
            delay_cnt  <= 32'd0;
            neuron_clk <= ~neuron_clk;
            tick       <= ~neuron_clk;
        end else begin
            delay_cnt  <= delay_cnt + 32'd1;
            tick       <= 1'b0;
        end
    end

endmodule

// File: rtl/neuron_sweep_scheduler.sv
// Sweep sequencer for the time-multiplexed neuron/synapse pool: one sweep of
// every neuron index x 4 RAM phases per step, with overrun detection.
module neuron_sweep_scheduler
    import neuron_sweep_scheduler_pkg::*;
#(
    parameter int NN = 8
) (
    input  logic          rawclk,
    input  logic          reset_sim_n,
    input  logic          enable,
    input  logic          single_step,
    input  logic [31:0]   half_cnt,
    input  logic          clear_overrun,
    output logic          neuron_clk,
    output logic [NN+2:0] neuronCounter,
    output logic [NN:0]   neuronIndex,
    output logic          neuronWriteCount,
    output logic          readClock,
    output logic          neuronWriteEnable,
    output logic          dataValid,
    output logic          busy,
    output logic          step_done,
    output logic          overrun,
    output logic [31:0]   step_count
);

    localparam int            CW   = NN + 3;
    localparam logic [CW-1:0] LAST = '1;  // SWEEP-1
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic       tick;
    logic       step_req;
    logic [1:0] state;
    logic       last_cyc;

    half_cnt_divider u_div (
        .rawclk      (rawclk),
        .reset_sim_n (reset_sim_n),
        .half_cnt    (half_cnt),
        .neuron_clk  (neuron_clk),
        .tick        (tick)
    );

    assign step_req = (enable && tick) || single_step;
    assign last_cyc = (state == SWEEP) && (neuronCounter == LAST);

    // Sweep FSM and neuron/phase counter
    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            state         <= IDLE;
            neuronCounter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    neuronCounter <= '0;
                    if (step_req) state <= SWEEP;
                end
                SWEEP: begin
                    if (last_cyc) begin
                        state         <= DONE;
                        neuronCounter <= '0;
                    end else begin
                        neuronCounter <= neuronCounter + ONE;
                    end
                end
                DONE: begin
                    neuronCounter <= '0;
                    state         <= step_req ? SWEEP : IDLE;
                end
                default: begin
                    state         <= IDLE;
                    neuronCounter <= '0;
                end
            endcase
        end
    end

    // Completed-sweep counter; bumps on the last phase so it reads updated during step_done
    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n)  step_count <= 32'd0;
        else if (last_cyc) step_count <= step_count + 32'd1;
    end

    // Sticky overrun: a dropped request beats a simultaneous clear
    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n)                     overrun <= 1'b0;
        else if (step_req && state == SWEEP) overrun <= 1'b1;
        else if (clear_overrun)               overrun <= 1'b0;
    end

    assign busy              = (state == SWEEP);
    assign step_done         = (state == DONE);
    assign neuronIndex       = neuronCounter[NN+2:2];
    assign neuronWriteCount  = busy && (neuronCounter[1:0] == PH_WCNT);
    assign readClock         = busy && (neuronCounter[1:0] == PH_READ);
    assign neuronWriteEnable = busy && (neuronCounter[1:0] == PH_WRITE);
    assign dataValid         = busy && (neuronCounter == '0);

endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// Self-checking bench for neuron_sweep_scheduler (NN=2, sweep of 32 cycles).
module tb_neuron_sweep_scheduler;

    localparam int NN = 2;
    localparam int SW = 32;

    logic        rawclk = 1'b0;
    logic        reset_sim_n;
    logic        enable, single_step, clear_overrun;
    logic [31:0] half_cnt;
    logic        neuron_clk;
    logic [4:0]  neuronCounter;
    logic [2:0]  neuronIndex;
    logic        neuronWriteCount, readClock, neuronWriteEnable, dataValid;
    logic        busy, step_done, overrun;
    logic [31:0] step_count;

    neuron_sweep_scheduler #(.NN(NN)) dut (
        .rawclk            (rawclk),
        .reset_sim_n       (reset_sim_n),
        .enable            (enable),
        .single_step       (single_step),
        .half_cnt          (half_cnt),
        .clear_overrun     (clear_overrun),
        .neuron_clk        (neuron_clk),
        .neuronCounter     (neuronCounter),
        .neuronIndex       (neuronIndex),
        .neuronWriteCount  (neuronWriteCount),
        .readClock         (readClock),
        .neuronWriteEnable (neuronWriteEnable),
        .dataValid         (dataValid),
        .busy              (busy),
        .step_done         (step_done),
        .overrun           (overrun),
        .step_count        (step_count)
    );

    always #5 rawclk = ~rawclk;

    int ntot = 0, npass = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(posedge rawclk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    // m_pos: -1 idle, 0..SW-1 position in sweep, SW = done cycle
    int          m_pos;
    int unsigned m_dly;
    logic        m_nclk, m_tick, m_ovr;
    logic [31:0] m_cnt;
    logic [31:0] m_ofs = 32'd0;  // offset applied when step_count is preloaded
    logic        m_req;
    logic        m_sweeping;

    assign m_req      = (enable && m_tick) || single_step;
    assign m_sweeping = (m_pos >= 0) && (m_pos < SW);

    always @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            m_pos <= -1; m_dly <= 0; m_nclk <= 1'b0; m_tick <= 1'b0;
            m_ovr <= 1'b0; m_cnt <= 32'd0;
        end else begin
            if (m_dly >= half_cnt) begin
                m_dly  <= 0;
                m_nclk <= !m_nclk;
                m_tick <= !m_nclk;
            end else begin
                m_dly  <= m_dly + 1;
                m_tick <= 1'b0;
            end
            if (m_sweeping) m_pos <= m_pos + 1;
            else            m_pos <= m_req ? 0 : -1;
            if (m_pos == SW - 1) m_cnt <= m_cnt + 32'd1;
            if (m_req && m_sweeping) m_ovr <= 1'b1;
            else if (clear_overrun)  m_ovr <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [4:0] e_ctr;
    assign e_ctr = m_sweeping ? m_pos[4:0] : 5'd0;

    always @(negedge rawclk) begin
        chk("busy",      busy,              m_sweeping);
        chk("counter",   neuronCounter,     e_ctr);
        chk("index",     neuronIndex,       e_ctr[4:2]);
        chk("wcount",    neuronWriteCount,  m_sweeping && e_ctr[1:0] == 2'd0);
        chk("readclk",   readClock,         m_sweeping && e_ctr[1:0] == 2'd1);
        chk("wenable",   neuronWriteEnable, m_sweeping && e_ctr[1:0] == 2'd3);
        chk("datavalid", dataValid,         m_sweeping && e_ctr == 5'd0);
        chk("step_done", step_done,         m_pos == SW);
        chk("overrun",   overrun,           m_ovr);
        chk("step_count", step_count,       m_cnt + m_ofs);
        chk("neuron_clk", neuron_clk,       m_nclk);
    end

    // ---------------- literal per-sweep properties ----------------
    int   n_wc = 0, n_rd = 0, n_we = 0, n_dv = 0, last_rise = 0;
    logic prev_nclk = 1'b0;
    bit   lat_en = 1'b0;

    always @(negedge rawclk) begin
        if (!reset_sim_n) begin
            n_wc = 0; n_rd = 0; n_we = 0; n_dv = 0;
        end else begin
            if (neuron_clk && !prev_nclk) last_rise = cyc;
            if (step_done) begin
                chk("sweep_wc", n_wc, 8);
                chk("sweep_rd", n_rd, 8);
                chk("sweep_we", n_we, 8);
                chk("sweep_dv", n_dv, 1);
                if (lat_en) chk("done_latency", cyc - last_rise, 33);
                n_wc = 0; n_rd = 0; n_we = 0; n_dv = 0;
            end
            n_wc += int'(neuronWriteCount);
            n_rd += int'(readClock);
            n_we += int'(neuronWriteEnable);
            n_dv += int'(dataValid);
        end
        prev_nclk = neuron_clk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge rawclk);
        #2;
    endtask

    task automatic wait_busy(input int bound);
        for (int i = 0; i < bound && !busy; i++) cycles(1);
        chk("wait_busy", busy, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && (busy || step_done); i++) cycles(1);
        chk("wait_idle", {busy, step_done}, 2'b00);
    endtask

    logic pv;

    initial begin
        reset_sim_n = 1'b0; enable = 1'b0; single_step = 1'b0;
        clear_overrun = 1'b0; half_cnt = 32'd19;
        cycles(3);

        // Free run, half_cnt=19: ticks at edges 20,60,100 after release
        reset_sim_n = 1'b1; enable = 1'b1; lat_en = 1'b1;
        cycles(10);
        chk("idle_before_tick", busy, 1'b0);
        cycles(125);
        chk("three_sweeps", step_count, 32'd3);
        chk("no_overrun", overrun, 1'b0);
        lat_en = 1'b0;

        // Reset mid-sweep: all outputs drop at once
        wait_busy(60);
        cycles(7);
        reset_sim_n = 1'b0;
        #1;
        chk("reset_outs", {neuron_clk, neuronCounter, neuronWriteCount, readClock,
                           neuronWriteEnable, dataValid, busy, step_done, overrun}, 32'd0);
        chk("reset_count", step_count, 32'd0);
        cycles(2);
        reset_sim_n = 1'b1;
        cycles(10);
        chk("idle_after_reset", busy, 1'b0);

        // half_cnt=9: second tick lands inside the sweep
        half_cnt = 32'd9;
        cycles(120);
        chk("overrun_set", overrun, 1'b1);
        enable = 1'b0;
        cycles(40);
        clear_overrun = 1'b1;
        cycles(1);
        clear_overrun = 1'b0;
        chk("overrun_cleared", overrun, 1'b0);
        enable = 1'b1;
        cycles(60);
        chk("overrun_again", overrun, 1'b1);
        enable = 1'b0;
        wait_idle(60);

        // Single step in IDLE, then a second one while busy
        clear_overrun = 1'b1; cycles(1); clear_overrun = 1'b0;
        single_step = 1'b1; cycles(1); single_step = 1'b0;
        chk("single_busy", busy, 1'b1);
        chk("single_first_ctr", neuronCounter, 5'd0);
        cycles(9);
        single_step = 1'b1; cycles(1); single_step = 1'b0;
        chk("single_overrun", overrun, 1'b1);
        cycles(30);
        chk("single_idle", busy, 1'b0);

        // single_step coinciding with tick: one sweep only
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge rawclk);
            if (m_tick) break;
        end
        single_step = 1'b1;
        @(posedge rawclk); #2;
        single_step = 1'b0; enable = 1'b0;
        chk("coincide_busy", busy, 1'b1);
        wait_idle(60);

        // half_cnt=0: toggle every edge
        half_cnt = 32'd0;
        cycles(1);
        pv = neuron_clk;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            chk("nclk_fast", neuron_clk, !pv);
            pv = neuron_clk;
        end
        // Lower 100 -> 5 while delay_cnt is 50: toggle on the next edge
        half_cnt = 32'd100;
        for (int i = 0; i < 300 && m_dly != 50; i++) cycles(1);
        chk("reach_dly50", m_dly, 32'd50);
        pv = neuron_clk;
        half_cnt = 32'd5;
        cycles(1);
        chk("nclk_lowered", neuron_clk, !pv);
        pv = neuron_clk;
        cycles(1);
        chk("nclk_hold", neuron_clk, pv);

        // step_count wrap; enable dropped mid-sweep
        wait_idle(60);
        force dut.step_count = 32'hFFFF_FFFF;
        m_ofs = 32'hFFFF_FFFF - m_cnt;
        cycles(1);
        release dut.step_count;
        half_cnt = 32'd19;
        enable = 1'b1;
        wait_busy(100);
        cycles(5);
        enable = 1'b0;
        cycles(40);
        chk("wrap_count", step_count, 32'd0);
        chk("wrap_idle", busy, 1'b0);
        cycles(60);
        chk("stays_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
